game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_if.sv | 28 ++
 rtl/game_sequencer.sv | 156 +++++++++++++++
 tb/tb_game_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Bundle of game-control signals between the keyboard/bird datapath side
// and the game sequencer. The master drives the keyboard/collision inputs;
// the slave (the sequencer) drives the game status outputs.
interface game_sequencer_if;
  logic [7:0] keycode;
  logic       collision;
  logic       pass_pulse;
  logic [1:0] state;
  logic       flap;
  logic       world_run;
  logic       world_rst;
  logic [7:0] cur_score;
  logic [7:0] high_score;
  logic       new_high;
  logic       paused;

  modport master (
    output keycode, collision, pass_pulse,
    input  state, flap, world_run, world_rst, cur_score, high_score,
           new_high, paused
  );

  modport slave (
    input  keycode, collision, pass_pulse,
    output state, flap, world_run, world_rst, cur_score, high_score,
           new_high, paused
  );
endinterface

// File: rtl/game_sequencer.sv
// Game sequencer: IDLE -> RUN -> DYING -> OVER state machine that turns
// keyboard edges, collisions and pipe passes into flap/world control pulses
// and keeps the current and best score.
// Optional feature: define GAME_PAUSE_EN to enable the P-key pause inside RUN.
module game_sequencer #(
  parameter int unsigned DEATH_FRAMES = 30,
  parameter logic [7:0]  KEY_FLAP     = 8'h2C,
  parameter logic [7:0]  KEY_RESTART  = 8'h15,
  parameter logic [7:0]  KEY_PAUSE    = 8'h13
) (
  input logic             frame_clk,
  input logic             Reset,
  game_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [5:0] DEATH_LOAD = 6'(DEATH_FRAMES - 1);

  state_t     state_q, state_next;
  logic [7:0] prev_key;
  logic [5:0] death_cnt, death_cnt_next;
  logic [7:0] score_q, score_next;
  logic [7:0] high_q, high_next;
  logic       new_high_q, new_high_next;
  logic       flap_q, flap_next;
  logic       world_rst_q, world_rst_next;
  logic       paused_q, paused_next;

  logic       flap_ev;
  logic       restart_ev;
  logic       pause_toggle;
  logic       frozen;

  // A key event fires only on the frame the keycode first shows that key.
  assign flap_ev    = (bus.keycode == KEY_FLAP)    && (prev_key != KEY_FLAP);
  assign restart_ev = (bus.keycode == KEY_RESTART) && (prev_key != KEY_RESTART);

`ifdef GAME_PAUSE_EN
  assign pause_toggle = (bus.keycode == KEY_PAUSE) && (prev_key != KEY_PAUSE);
  assign frozen       = paused_q;
`else
  // Without the pause feature the P key is decoded but never acted upon.
  logic unused_pause_key;
  assign unused_pause_key = (bus.keycode == KEY_PAUSE);
  assign pause_toggle     = 1'b0;
  assign frozen           = 1'b0;
`endif

  // State register and all frame-level storage, with Reset taking priority.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      prev_key    <= 8'h00;
      death_cnt   <= 6'd0;
      score_q     <= 8'd0;
      high_q      <= 8'd0;
      new_high_q  <= 1'b0;
      flap_q      <= 1'b0;
      world_rst_q <= 1'b1;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_next;
      prev_key    <= bus.keycode;
      death_cnt   <= death_cnt_next;
      score_q     <= score_next;
      high_q      <= high_next;
      new_high_q  <= new_high_next;
      flap_q      <= flap_next;
      world_rst_q <= world_rst_next;
      paused_q    <= paused_next;
    end
  end

  // Next-state and next-output decision for each game phase.
  always_comb begin
    state_next     = state_q;
    death_cnt_next = death_cnt;
    score_next     = score_q;
    high_next      = high_q;
    new_high_next  = new_high_q;
    flap_next      = 1'b0;
    world_rst_next = 1'b0;
    paused_next    = paused_q;

    case (state_q)
      IDLE: begin
        if (flap_ev) begin
          state_next    = RUN;
          flap_next     = 1'b1;
          score_next    = 8'd0;
          new_high_next = 1'b0;
        end
      end

      RUN: begin
        if (restart_ev) begin
          state_next     = IDLE;
          world_rst_next = 1'b1;
          score_next     = 8'd0;
          paused_next    = 1'b0;
        end else if (pause_toggle) begin
          paused_next = !paused_q;
        end else if (!frozen) begin
          if (bus.collision) begin
            state_next     = DYING;
            death_cnt_next = DEATH_LOAD;
          end else begin
            flap_next = flap_ev;
            if (bus.pass_pulse && (score_q != 8'hFF)) begin
              score_next = score_q + 8'd1;
            end
          end
        end
      end

      DYING: begin
        if (death_cnt == 6'd0) begin
          state_next = OVER;
          if (score_q > high_q) begin
            high_next     = score_q;
            new_high_next = 1'b1;
          end else begin
            new_high_next = 1'b0;
          end
        end else begin
          death_cnt_next = death_cnt - 6'd1;
        end
      end

      OVER: begin
        if (restart_ev) begin
          state_next     = IDLE;
          world_rst_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.flap       = flap_q;
  assign bus.world_run  = (state_q == RUN) && !paused_q;
  assign bus.world_rst  = world_rst_q;
  assign bus.cur_score  = score_q;
  assign bus.high_score = high_q;
  assign bus.new_high   = new_high_q;
  assign bus.paused     = paused_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer: expected values are queued as each
// frame of stimulus is driven and popped/checked once the frame edge passes.
module tb_game_sequencer;

  localparam logic [7:0] K_NONE    = 8'h00;
  localparam logic [7:0] K_FLAP    = 8'h2C;
  localparam logic [7:0] K_RESTART = 8'h15;
  localparam logic [7:0] K_PAUSE   = 8'h13;

  localparam int F_STATE  = 0;
  localparam int F_FLAP   = 1;
  localparam int F_RUN    = 2;
  localparam int F_RST    = 3;
  localparam int F_CUR    = 4;
  localparam int F_HIGH   = 5;
  localparam int F_NEWHI  = 6;
  localparam int F_PAUSED = 7;

  typedef struct {
    string      tag;
    int         field;
    logic [7:0] exp;
  } exp_t;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  int   compared  = 0;
  int   mismatched = 0;
  int   flap_seen = 0;
  exp_t sb[$];

  game_sequencer_if bus ();

  game_sequencer dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  // Free-running frame clock.
  always #5 frame_clk = ~frame_clk;

  function automatic logic [7:0] observed(input int field);
    case (field)
      F_STATE:  return {6'd0, bus.state};
      F_FLAP:   return {7'd0, bus.flap};
      F_RUN:    return {7'd0, bus.world_run};
      F_RST:    return {7'd0, bus.world_rst};
      F_CUR:    return bus.cur_score;
      F_HIGH:   return bus.high_score;
      F_NEWHI:  return {7'd0, bus.new_high};
      F_PAUSED: return {7'd0, bus.paused};
      default:  return 8'hXX;
    endcase
  endfunction

  task automatic expectVal(input string tag, input int field, input logic [7:0] v);
    sb.push_back('{tag, field, v});
  endtask

  task automatic compareVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    compareVal("flap_and_world_rst_exclusive", {7'd0, bus.flap & bus.world_rst}, 8'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      compareVal(e.tag, observed(e.field), e.exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] k, input logic c, input logic p);
    bus.keycode    = k;
    bus.collision  = c;
    bus.pass_pulse = p;
    @(posedge frame_clk);
    #1;
    if (bus.flap === 1'b1) flap_seen++;
  endtask

  task automatic expectResetValues(input string tag);
    expectVal({tag, "_state"},    F_STATE,  8'd0);
    expectVal({tag, "_flap"},     F_FLAP,   8'd0);
    expectVal({tag, "_run"},      F_RUN,    8'd0);
    expectVal({tag, "_wrst"},     F_RST,    8'd1);
    expectVal({tag, "_cur"},      F_CUR,    8'd0);
    expectVal({tag, "_high"},     F_HIGH,   8'd0);
    expectVal({tag, "_newhigh"},  F_NEWHI,  8'd0);
    expectVal({tag, "_paused"},   F_PAUSED, 8'd0);
  endtask

  // IDLE -> RUN with a single flap frame, then key released.
  task automatic startGame(input string tag);
    applyStimulus(K_FLAP, 1'b0, 1'b0);
    expectVal({tag, "_start_state"}, F_STATE, 8'd1);
    expectVal({tag, "_start_flap"},  F_FLAP,  8'd1);
    expectVal({tag, "_start_cur"},   F_CUR,   8'd0);
    expectVal({tag, "_start_newhi"}, F_NEWHI, 8'd0);
    checkOutput();
    applyStimulus(K_NONE, 1'b0, 1'b0);
  endtask

  // n single-frame pass pulses separated by idle frames, checking the count.
  task automatic scorePasses(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      applyStimulus(K_NONE, 1'b0, 1'b1);
      expectVal({tag, "_score"}, F_CUR, 8'(i));
      checkOutput();
      applyStimulus(K_NONE, 1'b0, 1'b0);
    end
  endtask

  // Remaining DYING frames after the collision edge, keys pressed to prove
  // they are ignored; then the frame that enters OVER.
  task automatic rideDying(input string tag);
    for (int i = 0; i < 29; i++) begin
      applyStimulus((i == 5) ? K_FLAP : ((i == 10) ? K_RESTART : K_NONE), 1'b0, 1'b0);
      expectVal({tag, "_dying_state"}, F_STATE, 8'd2);
      expectVal({tag, "_dying_flap"},  F_FLAP,  8'd0);
      checkOutput();
    end
    applyStimulus(K_NONE, 1'b0, 1'b0);
    expectVal({tag, "_over_state"}, F_STATE, 8'd3);
  endtask

  initial begin
    bus.keycode    = K_NONE;
    bus.collision  = 1'b0;
    bus.pass_pulse = 1'b0;

    // Reset state
    Reset = 1'b1;
    applyStimulus(K_NONE, 1'b0, 1'b0);
    applyStimulus(K_NONE, 1'b0, 1'b0);
    expectResetValues("reset");
    checkOutput();
    Reset = 1'b0;
    applyStimulus(K_NONE, 1'b0, 1'b0);
    expectVal("post_reset_wrst",  F_RST,   8'd0);
    expectVal("post_reset_state", F_STATE, 8'd0);
    checkOutput();

    // Held flap key: one flap pulse only
    flap_seen = 0;
    applyStimulus(K_FLAP, 1'b0, 1'b0);
    expectVal("g1_start_state", F_STATE, 8'd1);
    expectVal("g1_start_flap",  F_FLAP,  8'd1);
    expectVal("g1_start_run",   F_RUN,   8'd1);
    checkOutput();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(K_FLAP, 1'b0, 1'b0);
      expectVal("g1_held_flap",  F_FLAP,  8'd0);
      expectVal("g1_held_state", F_STATE, 8'd1);
      checkOutput();
    end
    compareVal("g1_flap_count", 8'(flap_seen), 8'd1);
    applyStimulus(K_NONE, 1'b0, 1'b0);

    // Game 1: three passes, collision, DYING, OVER with new high
    scorePasses("g1", 3);
    applyStimulus(K_NONE, 1'b1, 1'b0);
    expectVal("g1_coll_state", F_STATE, 8'd2);
    expectVal("g1_coll_run",   F_RUN,   8'd0);
    expectVal("g1_coll_cur",   F_CUR,   8'd3);
    checkOutput();
    rideDying("g1");
    expectVal("g1_over_high",  F_HIGH,  8'd3);
    expectVal("g1_over_newhi", F_NEWHI, 8'd1);
    expectVal("g1_over_cur",   F_CUR,   8'd3);
    checkOutput();
    applyStimulus(K_RESTART, 1'b0, 1'b0);
    expectVal("g1_restart_state", F_STATE, 8'd0);
    expectVal("g1_restart_wrst",  F_RST,   8'd1);
    expectVal("g1_restart_high",  F_HIGH,  8'd3);
    checkOutput();
    applyStimulus(K_NONE, 1'b0, 1'b0);
    expectVal("g1_restart_wrst_end", F_RST, 8'd0);
    checkOutput();

    // Game 2: equal score does not beat the high score
    startGame("g2");
    scorePasses("g2", 3);
    applyStimulus(K_NONE, 1'b1, 1'b0);
    expectVal("g2_coll_state", F_STATE, 8'd2);
    checkOutput();
    rideDying("g2");
    expectVal("g2_over_high",  F_HIGH,  8'd3);
    expectVal("g2_over_newhi", F_NEWHI, 8'd0);
    checkOutput();
    applyStimulus(K_RESTART, 1'b0, 1'b0);
    expectVal("g2_restart_state", F_STATE, 8'd0);
    expectVal("g2_restart_wrst",  F_RST,   8'd1);
    checkOutput();
    applyStimulus(K_NONE, 1'b0, 1'b0);
    expectVal("g2_restart_wrst_end", F_RST, 8'd0);
    checkOutput();

    // Game 3: collision and pass on the same frame at score 7
    startGame("g3");
    scorePasses("g3", 7);
    applyStimulus(K_NONE, 1'b1, 1'b1);
    expectVal("g3_coll_state", F_STATE, 8'd2);
    expectVal("g3_coll_cur",   F_CUR,   8'd7);
    checkOutput();
    rideDying("g3");
    expectVal("g3_over_high",  F_HIGH,  8'd7);
    expectVal("g3_over_newhi", F_NEWHI, 8'd1);
    checkOutput();
    applyStimulus(K_RESTART, 1'b0, 1'b0);
    applyStimulus(K_NONE, 1'b0, 1'b0);

    // Game 4: restart from RUN clears score, keeps high
    startGame("g4");
    scorePasses("g4", 2);
    applyStimulus(K_RESTART, 1'b0, 1'b0);
    expectVal("g4_runrst_state", F_STATE, 8'd0);
    expectVal("g4_runrst_wrst",  F_RST,   8'd1);
    expectVal("g4_runrst_flap",  F_FLAP,  8'd0);
    expectVal("g4_runrst_cur",   F_CUR,   8'd0);
    expectVal("g4_runrst_high",  F_HIGH,  8'd7);
    checkOutput();
    applyStimulus(K_NONE, 1'b0, 1'b0);

    // Game 5: score saturation, then Reset in the middle of DYING
    startGame("g5");
    for (int i = 0; i < 255; i++) applyStimulus(K_NONE, 1'b0, 1'b1);
    expectVal("g5_score_255", F_CUR, 8'd255);
    checkOutput();
    applyStimulus(K_NONE, 1'b0, 1'b1);
    expectVal("g5_score_sat", F_CUR, 8'd255);
    checkOutput();
    applyStimulus(K_NONE, 1'b1, 1'b0);
    expectVal("g5_coll_state", F_STATE, 8'd2);
    checkOutput();
    for (int i = 0; i < 5; i++) applyStimulus(K_NONE, 1'b0, 1'b0);
    Reset = 1'b1;
    applyStimulus(K_NONE, 1'b0, 1'b0);
    expectResetValues("dying_reset");
    checkOutput();
    Reset = 1'b0;
    applyStimulus(K_NONE, 1'b0, 1'b0);

    // Game 6: pause key behaviour
    startGame("g6");
`ifdef GAME_PAUSE_EN
    applyStimulus(K_PAUSE, 1'b0, 1'b0);
    expectVal("g6_pause_on",    F_PAUSED, 8'd1);
    expectVal("g6_pause_run",   F_RUN,    8'd0);
    expectVal("g6_pause_state", F_STATE,  8'd1);
    checkOutput();
    applyStimulus(K_NONE, 1'b0, 1'b1);
    expectVal("g6_pause_pass_ignored", F_CUR, 8'd0);
    checkOutput();
    applyStimulus(K_FLAP, 1'b0, 1'b0);
    expectVal("g6_pause_flap_ignored", F_FLAP, 8'd0);
    checkOutput();
    applyStimulus(K_NONE, 1'b1, 1'b0);
    expectVal("g6_pause_coll_ignored", F_STATE, 8'd1);
    checkOutput();
    applyStimulus(K_PAUSE, 1'b0, 1'b0);
    expectVal("g6_pause_off",     F_PAUSED, 8'd0);
    expectVal("g6_pause_off_run", F_RUN,    8'd1);
    checkOutput();
    applyStimulus(K_NONE, 1'b0, 1'b1);
    expectVal("g6_resume_score", F_CUR, 8'd1);
    checkOutput();
`else
    applyStimulus(K_PAUSE, 1'b0, 1'b0);
    expectVal("g6_nopause_paused", F_PAUSED, 8'd0);
    expectVal("g6_nopause_run",    F_RUN,    8'd1);
    expectVal("g6_nopause_state",  F_STATE,  8'd1);
    checkOutput();
    applyStimulus(K_NONE, 1'b0, 1'b1);
    expectVal("g6_nopause_score", F_CUR, 8'd1);
    checkOutput();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
